// File: rtl/npc_multicycle_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the npc core.
// Optional perf counters (cyc_cnt, instret_cnt) under NPC_CTRL_PERF_CNT_EN.
module npc_multicycle_ctrl #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifu_gnt,
    input  logic        ifu_rvalid,
    input  logic        lsu_gnt,
    input  logic        lsu_rvalid,
    input  logic        dec_mem_ren,
    input  logic        dec_mem_wen,
    input  logic        dec_wen,
    input  logic        dec_ebreak,
    input  logic        dec_illegal,
    output logic        ifu_req,
    output logic        inst_we,
    output logic        lsu_req,
    output logic        lsu_we,
    output logic        rf_wen,
    output logic        pc_wen,
    output logic        halt,
    output logic        err,
`ifdef NPC_CTRL_PERF_CNT_EN
    output logic [63:0] cyc_cnt,
    output logic [63:0] instret_cnt,
`endif
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_WAIT_I = 4'd2,
        S_DECODE = 4'd3,
        S_EXEC   = 4'd4,
        S_MEM    = 4'd5,
        S_WAIT_M = 4'd6,
        S_WB     = 4'd7,
        S_HALT   = 4'd8,
        S_ERR    = 4'd9
    } st_t;

    st_t             st;
    st_t             nxt;
    logic [CNT_W-1:0] cnt;
    logic            stall;
    logic            exit_c;

    always_comb begin
        nxt    = st;
        stall  = 1'b0;
        exit_c = 1'b1;
        case (st)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                stall  = 1'b1;
                exit_c = ifu_gnt;
                if (ifu_gnt) nxt = S_WAIT_I;
            end
            S_WAIT_I: begin
                stall  = 1'b1;
                exit_c = ifu_rvalid;
                if (ifu_rvalid) nxt = S_DECODE;
            end
            S_DECODE: begin
                if (dec_illegal)     nxt = S_ERR;
                else if (dec_ebreak) nxt = S_HALT;
                else                 nxt = S_EXEC;
            end
            S_EXEC: begin
                if (dec_mem_ren && dec_mem_wen)      nxt = S_ERR;
                else if (dec_mem_ren || dec_mem_wen) nxt = S_MEM;
                else                                 nxt = S_WB;
            end
            S_MEM: begin
                stall  = 1'b1;
                exit_c = lsu_gnt;
                if (lsu_gnt) nxt = S_WAIT_M;
            end
            S_WAIT_M: begin
                stall  = 1'b1;
                exit_c = lsu_rvalid;
                if (lsu_rvalid) nxt = S_WB;
            end
            S_WB:   nxt = S_FETCH;
            S_HALT: nxt = S_HALT;
            S_ERR:  nxt = S_ERR;
            default: nxt = S_IDLE;
        endcase
        // A normal exit in the timeout cycle takes precedence over ERR
        if (stall && !exit_c && cnt == CNT_W'(TIMEOUT_CYC))
            nxt = S_ERR;
    end

    // Moore outputs are registered from the next state so they line up with st
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= S_IDLE;
            cnt     <= '0;
            ifu_req <= 1'b0;
            lsu_req <= 1'b0;
            lsu_we  <= 1'b0;
            rf_wen  <= 1'b0;
            pc_wen  <= 1'b0;
            halt    <= 1'b0;
            err     <= 1'b0;
        end else begin
            st <= nxt;
            if (nxt != st || !stall) cnt <= '0;
            else                     cnt <= cnt + CNT_W'(1);
            ifu_req <= (nxt == S_FETCH);
            lsu_req <= (nxt == S_MEM);
            lsu_we  <= (nxt == S_MEM) && dec_mem_wen;
            rf_wen  <= (nxt == S_WB) && dec_wen;
            pc_wen  <= (nxt == S_WB);
            halt    <= (nxt == S_HALT);
            err     <= (nxt == S_ERR);
        end
    end

    assign inst_we = (st == S_WAIT_I) && ifu_rvalid;
    assign state   = st;

`ifdef NPC_CTRL_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt     <= '0;
            instret_cnt <= '0;
        end else begin
            if (st != S_IDLE && st != S_HALT && st != S_ERR)
                cyc_cnt <= cyc_cnt + 64'd1;
            if (st == S_WB)
                instret_cnt <= instret_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_npc_multicycle_ctrl.sv
// Directed vector bench for npc_multicycle_ctrl (TIMEOUT_CYC=4).
// Table rows apply inputs for one cycle and check state/outputs in that cycle.
module tb_npc_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic ifu_gnt, ifu_rvalid, lsu_gnt, lsu_rvalid;
    logic dec_mem_ren, dec_mem_wen, dec_wen, dec_ebreak, dec_illegal;
    logic ifu_req, inst_we, lsu_req, lsu_we, rf_wen, pc_wen, halt, err;
    logic [3:0] state;
`ifdef NPC_CTRL_PERF_CNT_EN
    logic [63:0] cyc_cnt, instret_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int exp_cyc = 0;
    int exp_ret = 0;

    always #5 clk = ~clk;

    npc_multicycle_ctrl #(.TIMEOUT_CYC(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_gnt(ifu_gnt), .ifu_rvalid(ifu_rvalid),
        .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
        .dec_mem_ren(dec_mem_ren), .dec_mem_wen(dec_mem_wen),
        .dec_wen(dec_wen), .dec_ebreak(dec_ebreak),
        .dec_illegal(dec_illegal),
        .ifu_req(ifu_req), .inst_we(inst_we),
        .lsu_req(lsu_req), .lsu_we(lsu_we),
        .rf_wen(rf_wen), .pc_wen(pc_wen),
        .halt(halt), .err(err),
`ifdef NPC_CTRL_PERF_CNT_EN
        .cyc_cnt(cyc_cnt), .instret_cnt(instret_cnt),
`endif
        .state(state)
    );

    // in  = {ifu_gnt,ifu_rvalid,lsu_gnt,lsu_rvalid,ren,wen,dec_wen,ebreak,illegal}
    // out = {ifu_req,inst_we,lsu_req,lsu_we,rf_wen,pc_wen,halt,err}
    typedef struct {
        logic       rst;
        logic [8:0] in;
        logic [3:0] st;
        logic [7:0] o;
        string      nm;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [8:0] i, logic [3:0] s,
                                logic [7:0] o, string n);
        vec_t v;
        v.rst = r; v.in = i; v.st = s; v.o = o; v.nm = n;
        return v;
    endfunction

    task automatic drive(input logic [8:0] i);
        {ifu_gnt, ifu_rvalid, lsu_gnt, lsu_rvalid, dec_mem_ren,
         dec_mem_wen, dec_wen, dec_ebreak, dec_illegal} = i;
    endtask

    task automatic check(input string nm, input logic [3:0] s,
                         input logic [7:0] o);
        logic [7:0] a;
        a = {ifu_req, inst_we, lsu_req, lsu_we, rf_wen, pc_wen, halt, err};
        checks++;
        if (state !== s || a !== o) begin
            failures++;
            $display("FAIL %s: got state=%0d out=%b, want state=%0d out=%b",
                     nm, state, a, s, o);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cyc(input logic [8:0] i, input logic [3:0] s,
                       input logic [7:0] o, input string nm);
        drive(i);
        #1;
        check(nm, s, o);
        if (s != 4'd0 && s != 4'd8 && s != 4'd9) exp_cyc++;
        if (s == 4'd7) exp_ret++;
        @(negedge clk);
    endtask

    // Called at a negedge; releases reset 2 time units later, before posedge.
    task automatic do_reset();
        drive(9'b0);
        rst_n = 1'b0;
        exp_cyc = 0;
        exp_ret = 0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic run_tbl();
        foreach (tbl[k]) begin
            if (tbl[k].rst) do_reset();
            else cyc(tbl[k].in, tbl[k].st, tbl[k].o, tbl[k].nm);
        end
        tbl.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(9'b0);
        #1;
        check("reset_state", 4'd0, 8'b0);
        @(negedge clk);
        check("reset_held", 4'd0, 8'b0);

        // ALU, load with delayed gnt, store, then ebreak (gnt+rvalid together)
        tbl.push_back(mk(1, 9'b0, 0, 0, "rst"));
        tbl.push_back(mk(0, 9'b000000100, 0, 8'b00000000, "alu_idle"));
        tbl.push_back(mk(0, 9'b100000100, 1, 8'b10000000, "alu_fetch"));
        tbl.push_back(mk(0, 9'b010000100, 2, 8'b01000000, "alu_wait_i"));
        tbl.push_back(mk(0, 9'b000000100, 3, 8'b00000000, "alu_decode"));
        tbl.push_back(mk(0, 9'b000000100, 4, 8'b00000000, "alu_exec"));
        tbl.push_back(mk(0, 9'b000000100, 7, 8'b00001100, "alu_wb"));
        tbl.push_back(mk(0, 9'b100010100, 1, 8'b10000000, "ld_fetch"));
        tbl.push_back(mk(0, 9'b010010100, 2, 8'b01000000, "ld_wait_i"));
        tbl.push_back(mk(0, 9'b000010100, 3, 8'b00000000, "ld_decode"));
        tbl.push_back(mk(0, 9'b000010100, 4, 8'b00000000, "ld_exec"));
        tbl.push_back(mk(0, 9'b000010100, 5, 8'b00100000, "ld_mem0"));
        tbl.push_back(mk(0, 9'b000010100, 5, 8'b00100000, "ld_mem1"));
        tbl.push_back(mk(0, 9'b000010100, 5, 8'b00100000, "ld_mem2"));
        tbl.push_back(mk(0, 9'b001010100, 5, 8'b00100000, "ld_mem3_gnt"));
        tbl.push_back(mk(0, 9'b000010100, 6, 8'b00000000, "ld_wait_m0"));
        tbl.push_back(mk(0, 9'b000110100, 6, 8'b00000000, "ld_wait_m1"));
        tbl.push_back(mk(0, 9'b000010100, 7, 8'b00001100, "ld_wb"));
        tbl.push_back(mk(0, 9'b100001000, 1, 8'b10000000, "st_fetch"));
        tbl.push_back(mk(0, 9'b010001000, 2, 8'b01000000, "st_wait_i"));
        tbl.push_back(mk(0, 9'b000001000, 3, 8'b00000000, "st_decode"));
        tbl.push_back(mk(0, 9'b000001000, 4, 8'b00000000, "st_exec"));
        tbl.push_back(mk(0, 9'b001001000, 5, 8'b00110000, "st_mem"));
        tbl.push_back(mk(0, 9'b000101000, 6, 8'b00000000, "st_wait_m"));
        tbl.push_back(mk(0, 9'b000001000, 7, 8'b00000100, "st_wb"));
        tbl.push_back(mk(0, 9'b110000010, 1, 8'b10000000, "eb_fetch_gnt_rv"));
        tbl.push_back(mk(0, 9'b010000010, 2, 8'b01000000, "eb_wait_i"));
        tbl.push_back(mk(0, 9'b000000010, 3, 8'b00000000, "eb_decode"));
        tbl.push_back(mk(0, 9'b000000010, 8, 8'b00000010, "eb_halt"));
        run_tbl();

        for (int k = 0; k < 20; k++) begin
            logic [8:0] r;
            r = 9'($urandom) | 9'b100000000;
            cyc(r, 4'd8, 8'b00000010, "halt_sticky");
        end

`ifdef NPC_CTRL_PERF_CNT_EN
        checks++;
        if (cyc_cnt !== 64'(exp_cyc) || instret_cnt !== 64'(exp_ret)) begin
            failures++;
            $display("FAIL perf_cnt: got cyc=%0d ret=%0d, want cyc=%0d ret=%0d",
                     cyc_cnt, instret_cnt, exp_cyc, exp_ret);
        end
`endif

        // Illegal opcode, ren+wen conflict, fetch timeout, gnt at the limit
        tbl.push_back(mk(1, 9'b0, 0, 0, "rst"));
        tbl.push_back(mk(0, 9'b000000000, 0, 8'b00000000, "ill_idle"));
        tbl.push_back(mk(0, 9'b100000000, 1, 8'b10000000, "ill_fetch"));
        tbl.push_back(mk(0, 9'b010000011, 2, 8'b01000000, "ill_wait_i"));
        tbl.push_back(mk(0, 9'b000000011, 3, 8'b00000000, "ill_decode"));
        tbl.push_back(mk(0, 9'b000000000, 9, 8'b00000001, "ill_err"));
        tbl.push_back(mk(0, 9'b100000000, 9, 8'b00000001, "ill_err_sticky"));
        tbl.push_back(mk(1, 9'b0, 0, 0, "rst"));
        tbl.push_back(mk(0, 9'b000000000, 0, 8'b00000000, "rw_idle"));
        tbl.push_back(mk(0, 9'b100011000, 1, 8'b10000000, "rw_fetch"));
        tbl.push_back(mk(0, 9'b010011000, 2, 8'b01000000, "rw_wait_i"));
        tbl.push_back(mk(0, 9'b000011000, 3, 8'b00000000, "rw_decode"));
        tbl.push_back(mk(0, 9'b000011000, 4, 8'b00000000, "rw_exec"));
        tbl.push_back(mk(0, 9'b000011000, 9, 8'b00000001, "rw_err"));
        tbl.push_back(mk(1, 9'b0, 0, 0, "rst"));
        tbl.push_back(mk(0, 9'b000000000, 0, 8'b00000000, "to_idle"));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 9'b0, 1, 8'b10000000, "to_fetch_stall"));
        tbl.push_back(mk(0, 9'b100000000, 9, 8'b00000001, "to_err"));
        tbl.push_back(mk(0, 9'b010000000, 9, 8'b00000001, "to_err_sticky"));
        tbl.push_back(mk(1, 9'b0, 0, 0, "rst"));
        tbl.push_back(mk(0, 9'b000000000, 0, 8'b00000000, "tg_idle"));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, 9'b0, 1, 8'b10000000, "tg_fetch_stall"));
        tbl.push_back(mk(0, 9'b100000000, 1, 8'b10000000, "tg_fetch_gnt4"));
        tbl.push_back(mk(0, 9'b000000000, 2, 8'b00000000, "tg_wait_i"));
        tbl.push_back(mk(0, 9'b010000100, 2, 8'b01000000, "tg_wait_i_rv"));
        tbl.push_back(mk(0, 9'b000000100, 3, 8'b00000000, "tg_decode"));
        run_tbl();

        // Asynchronous reset while parked in MEM
        do_reset();
        cyc(9'b000010100, 4'd0, 8'b00000000, "ar_idle");
        cyc(9'b100010100, 4'd1, 8'b10000000, "ar_fetch");
        cyc(9'b010010100, 4'd2, 8'b01000000, "ar_wait_i");
        cyc(9'b000010100, 4'd3, 8'b00000000, "ar_decode");
        cyc(9'b000010100, 4'd4, 8'b00000000, "ar_exec");
        cyc(9'b000010100, 4'd5, 8'b00100000, "ar_mem");
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_async_clear", 4'd0, 8'b00000000);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(9'b000010100, 4'd0, 8'b00000000, "ar_post_idle");
        cyc(9'b000010100, 4'd1, 8'b10000000, "ar_post_fetch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
